// File: rtl/port_demux_if.sv
// port_demux_if: one NetFPGA-style data-path stream (word, ctrl, write strobe, ready).
//   data  word on the bus
//   ctrl  ctrl byte-lane flags; nonzero marks a module header or the EOP word
//   wr    word valid / write strobe (driven by master)
//   rdy   receiver can take a word (driven by slave)
interface port_demux_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, output ctrl, output wr, input rdy);
  modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/port_demux.sv
// port_demux: packet-aware 1-to-2 stream splitter. Each whole packet is steered to
// out_0 or out_1 according to select, sampled on the first word of the packet.
// Registered output stage (latency 1) and per-output completed-packet counters.
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   in_if        input stream (slave); in_if.rdy is combinational
//   out_0_if     output stream 0 (master), registered data/ctrl/wr
//   out_1_if     output stream 1 (master), registered data/ctrl/wr
//   select       destination for the next packet: 0 -> out_0, 1 -> out_1
//   pkt_cnt_0/1  packets completed on each output, wrapping
module port_demux #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  port_demux_if.slave          in_if,
  port_demux_if.master         out_0_if,
  port_demux_if.master         out_1_if,
  input  logic                 select,
  output logic [CNT_WIDTH-1:0] pkt_cnt_0,
  output logic [CNT_WIDTH-1:0] pkt_cnt_1
);

  localparam logic [0:0] HDR     = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  sop_q, sop_d;
  logic                  dst_q, dst_d;
  logic [DATA_WIDTH-1:0] out_data_0_q, out_data_0_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_0_q, out_ctrl_0_d;
  logic                  out_wr_0_q, out_wr_0_d;
  logic [DATA_WIDTH-1:0] out_data_1_q, out_data_1_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_1_q, out_ctrl_1_d;
  logic                  out_wr_1_q, out_wr_1_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_0_q, pkt_cnt_0_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_1_q, pkt_cnt_1_d;

  logic in_rdy;
  logic accept;
  logic port;
  logic has_ctrl;
  logic eop;

  always_comb begin
    // On the first word the destination is still the live select; afterwards the latched one.
    port     = sop_q ? select : dst_q;
    in_rdy   = port ? out_1_if.rdy : out_0_if.rdy;
    accept   = in_if.wr & in_rdy;
    has_ctrl = |in_if.ctrl;
    // A nonzero ctrl word is only an EOP once payload has started; before that it is a header.
    eop      = accept & has_ctrl & (state_q == PAYLOAD);

    state_d      = state_q;
    sop_d        = sop_q;
    dst_d        = dst_q;
    out_data_0_d = out_data_0_q;
    out_ctrl_0_d = out_ctrl_0_q;
    out_wr_0_d   = 1'b0;
    out_data_1_d = out_data_1_q;
    out_ctrl_1_d = out_ctrl_1_q;
    out_wr_1_d   = 1'b0;
    pkt_cnt_0_d  = pkt_cnt_0_q;
    pkt_cnt_1_d  = pkt_cnt_1_q;

    if (accept) begin
      if (sop_q) begin
        dst_d = select;
        sop_d = 1'b0;
      end

      if (!has_ctrl) begin
        state_d = PAYLOAD;
      end else if (state_q == PAYLOAD) begin
        state_d = HDR;
        sop_d   = 1'b1;
      end

      if (port) begin
        out_data_1_d = in_if.data;
        out_ctrl_1_d = in_if.ctrl;
        out_wr_1_d   = 1'b1;
      end else begin
        out_data_0_d = in_if.data;
        out_ctrl_0_d = in_if.ctrl;
        out_wr_0_d   = 1'b1;
      end
    end

    if (eop) begin
      if (port) pkt_cnt_1_d = pkt_cnt_1_q + CNT_WIDTH'(1);
      else      pkt_cnt_0_d = pkt_cnt_0_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HDR;
      sop_q        <= 1'b1;
      dst_q        <= 1'b0;
      out_data_0_q <= '0;
      out_ctrl_0_q <= '0;
      out_wr_0_q   <= 1'b0;
      out_data_1_q <= '0;
      out_ctrl_1_q <= '0;
      out_wr_1_q   <= 1'b0;
      pkt_cnt_0_q  <= '0;
      pkt_cnt_1_q  <= '0;
    end else begin
      state_q      <= state_d;
      sop_q        <= sop_d;
      dst_q        <= dst_d;
      out_data_0_q <= out_data_0_d;
      out_ctrl_0_q <= out_ctrl_0_d;
      out_wr_0_q   <= out_wr_0_d;
      out_data_1_q <= out_data_1_d;
      out_ctrl_1_q <= out_ctrl_1_d;
      out_wr_1_q   <= out_wr_1_d;
      pkt_cnt_0_q  <= pkt_cnt_0_d;
      pkt_cnt_1_q  <= pkt_cnt_1_d;
    end
  end

  assign in_if.rdy     = in_rdy;
  assign out_0_if.data = out_data_0_q;
  assign out_0_if.ctrl = out_ctrl_0_q;
  assign out_0_if.wr   = out_wr_0_q;
  assign out_1_if.data = out_data_1_q;
  assign out_1_if.ctrl = out_ctrl_1_q;
  assign out_1_if.wr   = out_wr_1_q;
  assign pkt_cnt_0     = pkt_cnt_0_q;
  assign pkt_cnt_1     = pkt_cnt_1_q;

endmodule

// File: tb/tb_port_demux.sv
// tb_port_demux: directed bench for port_demux (CNT_WIDTH=4 build so counter wrap is reachable).
module tb_port_demux;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          select;
  logic [NW-1:0] pkt_cnt_0;
  logic [NW-1:0] pkt_cnt_1;

  int n_checks = 0;
  int n_errors = 0;

  port_demux_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_if ();
  port_demux_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_0_if ();
  port_demux_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_1_if ();

  port_demux #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (in_if),
    .out_0_if  (out_0_if),
    .out_1_if  (out_1_if),
    .select    (select),
    .pkt_cnt_0 (pkt_cnt_0),
    .pkt_cnt_1 (pkt_cnt_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_if.wr = 1'b0;
    step();
  endtask

  // Present one word for acceptance; afterwards it must appear on exactly port exp_port.
  task automatic xfer(input logic [63:0] d, input logic [7:0] c, input logic sel, input int exp_port);
    in_if.data = d;
    in_if.ctrl = c;
    in_if.wr   = 1'b1;
    select     = sel;
    #1;
    chk("in_rdy", 64'(in_if.rdy), 64'd1);
    step();
    chk("out_wr_0", 64'(out_0_if.wr), 64'(exp_port == 0));
    chk("out_wr_1", 64'(out_1_if.wr), 64'(exp_port == 1));
    if (exp_port == 0) begin
      chk("out_data_0", out_0_if.data, d);
      chk("out_ctrl_0", 64'(out_0_if.ctrl), 64'(c));
    end else begin
      chk("out_data_1", out_1_if.data, d);
      chk("out_ctrl_1", 64'(out_1_if.ctrl), 64'(c));
    end
  endtask

  task automatic chk_cnts(input string tag, input int c0, input int c1);
    chk({tag, "_cnt0"}, 64'(pkt_cnt_0), 64'(c0));
    chk({tag, "_cnt1"}, 64'(pkt_cnt_1), 64'(c1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr0"},   64'(out_0_if.wr),   64'd0);
    chk({tag, "_wr1"},   64'(out_1_if.wr),   64'd0);
    chk({tag, "_data0"}, out_0_if.data,      64'd0);
    chk({tag, "_ctrl0"}, 64'(out_0_if.ctrl), 64'd0);
    chk({tag, "_data1"}, out_1_if.data,      64'd0);
    chk({tag, "_ctrl1"}, 64'(out_1_if.ctrl), 64'd0);
    chk_cnts(tag, 0, 0);
  endtask

  initial begin
    reset        = 1'b1;
    select       = 1'b0;
    in_if.data   = '0;
    in_if.ctrl   = '0;
    in_if.wr     = 1'b0;
    out_0_if.rdy = 1'b1;
    out_1_if.rdy = 1'b1;
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    // 1: 2 headers + 4 data + EOP to out_0
    xfer(64'hAAAA_0000_0000_0001, 8'hFF, 1'b0, 0);
    xfer(64'hAAAA_0000_0000_0002, 8'hFF, 1'b0, 0);
    xfer(64'hD000_0000_0000_0001, 8'h00, 1'b0, 0);
    xfer(64'hD000_0000_0000_0002, 8'h00, 1'b0, 0);
    xfer(64'hD000_0000_0000_0003, 8'h00, 1'b0, 0);
    xfer(64'hD000_0000_0000_0004, 8'h00, 1'b0, 0);
    chk_cnts("t1_pre_eop", 0, 0);
    xfer(64'hE000_0000_0000_0001, 8'h10, 1'b0, 0);
    chk_cnts("t1_eop", 1, 0);
    idle();
    chk("t1_idle_wr0", 64'(out_0_if.wr), 64'd0);
    chk("t1_idle_hold", out_0_if.data, 64'hE000_0000_0000_0001);

    // 2: select flips mid-payload; packet stays on out_0, next goes to out_1
    xfer(64'hAAAA_0000_0000_0021, 8'hFF, 1'b0, 0);
    xfer(64'hD000_0000_0000_0021, 8'h00, 1'b0, 0);
    xfer(64'hD000_0000_0000_0022, 8'h00, 1'b1, 0);
    xfer(64'hD000_0000_0000_0023, 8'h00, 1'b1, 0);
    xfer(64'hE000_0000_0000_0021, 8'h10, 1'b1, 0);
    chk_cnts("t2_a", 2, 0);
    xfer(64'hAAAA_0000_0000_0031, 8'hFF, 1'b1, 1);
    xfer(64'hD000_0000_0000_0031, 8'h00, 1'b1, 1);
    xfer(64'hE000_0000_0000_0031, 8'h10, 1'b1, 1);
    chk_cnts("t2_b", 2, 1);
    idle();

    // 3: back-to-back A->out_1, B->out_0, no bubble
    xfer(64'hAAAA_0000_0000_0041, 8'hFF, 1'b1, 1);
    xfer(64'hD000_0000_0000_0041, 8'h00, 1'b1, 1);
    xfer(64'hE000_0000_0000_0041, 8'h10, 1'b1, 1);
    chk_cnts("t3_a", 2, 2);
    xfer(64'hAAAA_0000_0000_0051, 8'hFF, 1'b0, 0);
    xfer(64'hD000_0000_0000_0051, 8'h00, 1'b0, 0);
    xfer(64'hE000_0000_0000_0051, 8'h10, 1'b0, 0);
    chk_cnts("t3_b", 3, 2);
    idle();

    // 4: backpressure on out_1 while dst=1; select=0 must not reopen the input
    xfer(64'hAAAA_0000_0000_0061, 8'hFF, 1'b1, 1);
    out_1_if.rdy = 1'b0;
    select       = 1'b0;
    in_if.data   = 64'hBAD0_0000_0000_0001;
    in_if.ctrl   = 8'h00;
    in_if.wr     = 1'b1;
    #1;
    chk("t4_in_rdy_low", 64'(in_if.rdy), 64'd0);
    step();
    chk("t4_wr0_a", 64'(out_0_if.wr), 64'd0);
    chk("t4_wr1_a", 64'(out_1_if.wr), 64'd0);
    chk("t4_hold1", out_1_if.data, 64'hAAAA_0000_0000_0061);
    in_if.wr = 1'b0;
    step();
    in_if.data = 64'hBAD0_0000_0000_0002;
    in_if.ctrl = 8'h10;
    in_if.wr   = 1'b1;
    step();
    chk("t4_wr0_b", 64'(out_0_if.wr), 64'd0);
    chk("t4_wr1_b", 64'(out_1_if.wr), 64'd0);
    chk_cnts("t4_stall", 3, 2);
    out_1_if.rdy = 1'b1;
    xfer(64'hD000_0000_0000_0061, 8'h00, 1'b0, 1);
    xfer(64'hE000_0000_0000_0061, 8'h10, 1'b0, 1);
    chk_cnts("t4_done", 3, 3);
    idle();

    // 5: reset mid-payload, then a ctrl=0 word starts a new packet to current select
    xfer(64'hAAAA_0000_0000_0071, 8'hFF, 1'b0, 0);
    xfer(64'hD000_0000_0000_0071, 8'h00, 1'b0, 0);
    in_if.wr = 1'b0;
    reset    = 1'b1;
    step();
    chk_zero("t5_reset");
    reset = 1'b0;
    xfer(64'hD000_0000_0000_0081, 8'h00, 1'b1, 1);
    xfer(64'hE000_0000_0000_0081, 8'h10, 1'b1, 1);
    chk_cnts("t5_after", 0, 1);
    idle();

    // 6: 4-bit counter wraps on the 16th packet
    for (int p = 0; p < 16; p++) begin
      xfer(64'(p) | 64'hC000_0000_0000_0000, 8'h00, 1'b0, 0);
      xfer(64'(p) | 64'hE000_0000_0000_0000, 8'h01, 1'b0, 0);
      if (p == 14) chk_cnts("t6_pre_wrap", 15, 1);
    end
    chk_cnts("t6_wrap", 0, 1);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
